ln_request_sequencer: RTL and testbench

LN_REQUEST_SEQUENCER -- requirements
Module: ln_request_sequencer

---
 rtl/ln_request_sequencer_pkg.sv | 25 ++
 rtl/ln_request_sequencer_timeout_counter.sv | 36 +++
 rtl/ln_request_sequencer.sv | 131 +++++++++++++
 tb/tb_ln_request_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ln_request_sequencer_pkg.sv
// Shared definitions for the request sequencer and the linearizer/normalizer core:
// word widths, timeout default and the sequencer state encoding.
package ln_request_sequencer_pkg;

  localparam int unsigned LN_P              = 32;   // sample/result word width
  localparam int unsigned LN_TO_CYC_DEFAULT = 255;  // default WAIT_ACK cycle budget
  localparam int unsigned LN_RES_W          = 32;   // core result width
  localparam int unsigned LN_CNT_W          = 16;   // timeout counter width
  localparam int unsigned LN_DONE_W         = 16;   // delivered-result counter width

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_START    = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_OUT      = 3'd4,
    ST_ABORT    = 3'd5
  } ln_state_e;

  // Last counter value of a WAIT_ACK window that is to_cyc cycles long.
  function automatic logic [LN_CNT_W-1:0] ln_term_count(input int unsigned to_cyc);
    return LN_CNT_W'(to_cyc - 1);
  endfunction

endpackage

// File: rtl/ln_request_sequencer_timeout_counter.sv
// ln_timeout_counter: counts WAIT_ACK cycles for the request sequencer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : clear the count to 0 (takes priority over enable)
//   enable     : advance the count by one (holds at the terminal value)
//   tc_c       : combinational flag, count equals TO_CYC-1
module ln_timeout_counter
  import ln_request_sequencer_pkg::*;
#(
  parameter int unsigned TO_CYC = LN_TO_CYC_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic enable,
  output logic tc_c
);

  localparam logic [LN_CNT_W-1:0] TERM = ln_term_count(TO_CYC);

  logic [LN_CNT_W-1:0] cnt;

  // Cycle counter; saturates at the terminal value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (enable && !tc_c) begin
      cnt <= cnt + LN_CNT_W'(1);
    end
  end

  assign tc_c = (cnt == TERM);

endmodule

// File: rtl/ln_request_sequencer.sv
// ln_request_sequencer: accepts one floating-point sample at a time, clears and
// starts the linearizer/normalizer core, waits (bounded) for its acknowledge and
// hands the result downstream over a valid/ready handshake.
// Ports:
//   clk, rst_n                         : clock, asynchronous active-low reset
//   sample_in/sample_valid/sample_ready: upstream sample handshake
//   t                                  : registered sample presented to the core
//   rst_fsm_ln_ff, begin_fsm_ln        : one-cycle clear / start pulses to the core
//   ack_ff, result                     : core completion level and result word
//   data_out/data_valid/data_ready     : downstream result handshake
//   busy, timeout_err, done_cnt        : status, timeout pulse, delivered count
module ln_request_sequencer
  import ln_request_sequencer_pkg::*;
#(
  parameter int unsigned P      = LN_P,
  parameter int unsigned TO_CYC = LN_TO_CYC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [P-1:0]         sample_in,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  output logic [P-1:0]         t,
  output logic                 rst_fsm_ln_ff,
  output logic                 begin_fsm_ln,
  input  logic                 ack_ff,
  input  logic [LN_RES_W-1:0]  result,
  output logic [LN_RES_W-1:0]  data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [LN_DONE_W-1:0] done_cnt
);

  ln_state_e             state;
  ln_state_e             state_nxt;
  logic [P-1:0]          t_nxt;
  logic [LN_RES_W-1:0]   data_out_nxt;
  logic [LN_DONE_W-1:0]  done_cnt_nxt;
  logic                  cnt_load_c;
  logic                  cnt_en_c;
  logic                  tc_c;

  ln_timeout_counter #(
    .TO_CYC (TO_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (cnt_load_c),
    .enable (cnt_en_c),
    .tc_c   (tc_c)
  );

  // Next-state and datapath update; ack_ff is only looked at in WAIT_ACK, and an
  // acknowledge on the terminal cycle takes precedence over the timeout.
  always_comb begin
    state_nxt    = state;
    t_nxt        = t;
    data_out_nxt = data_out;
    done_cnt_nxt = done_cnt;
    cnt_load_c   = 1'b0;
    cnt_en_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sample_valid && sample_ready) begin
          t_nxt     = sample_in;
          state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        state_nxt = ST_START;
      end
      ST_START: begin
        cnt_load_c = 1'b1;
        state_nxt  = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (ack_ff) begin
          data_out_nxt = result;
          state_nxt    = ST_OUT;
        end else if (tc_c) begin
          state_nxt = ST_ABORT;
        end else begin
          cnt_en_c = 1'b1;
        end
      end
      ST_OUT: begin
        if (data_ready) begin
          done_cnt_nxt = done_cnt + LN_DONE_W'(1);
          state_nxt    = ST_IDLE;
        end
      end
      ST_ABORT: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; the status/pulse outputs are decoded from the
  // next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      t             <= '0;
      data_out      <= '0;
      done_cnt      <= '0;
      sample_ready  <= 1'b0;
      busy          <= 1'b0;
      rst_fsm_ln_ff <= 1'b0;
      begin_fsm_ln  <= 1'b0;
      data_valid    <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state         <= state_nxt;
      t             <= t_nxt;
      data_out      <= data_out_nxt;
      done_cnt      <= done_cnt_nxt;
      sample_ready  <= (state_nxt == ST_IDLE);
      busy          <= (state_nxt != ST_IDLE);
      rst_fsm_ln_ff <= (state_nxt == ST_CLEAR) || (state_nxt == ST_ABORT);
      begin_fsm_ln  <= (state_nxt == ST_START);
      data_valid    <= (state_nxt == ST_OUT);
      timeout_err   <= (state_nxt == ST_ABORT);
    end
  end

endmodule

// File: tb/tb_ln_request_sequencer.sv
// Self-checking bench for ln_request_sequencer (TO_CYC shortened to 8).
// Expected waveforms are derived from the request timeline: after the accepting
// edge, cycle 1 is the clear pulse, cycle 2 the start pulse, cycles 3.. wait for
// the acknowledge; an ack in wait cycle d gives valid data from cycle 4+d, while
// no ack within TO_CYC wait cycles gives the abort cycle at 3+TO_CYC.
module tb_ln_request_sequencer;

  localparam int unsigned TO_CYC = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic [31:0] t;
  logic        rst_fsm_ln_ff;
  logic        begin_fsm_ln;
  logic        ack_ff;
  logic [31:0] result;
  logic [31:0] data_out;
  logic        data_valid;
  logic        data_ready;
  logic        busy;
  logic        timeout_err;
  logic [15:0] done_cnt;

  int          vectors    = 0;
  int          miscompares = 0;

  // Reference state: what the sequencer should be holding while idle.
  logic [31:0] m_t;
  logic [31:0] m_dout;
  logic [15:0] m_done;

  always #5 clk = ~clk;

  ln_request_sequencer #(
    .P      (32),
    .TO_CYC (TO_CYC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_in     (sample_in),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .t             (t),
    .rst_fsm_ln_ff (rst_fsm_ln_ff),
    .begin_fsm_ln  (begin_fsm_ln),
    .ack_ff        (ack_ff),
    .result        (result),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .busy          (busy),
    .timeout_err   (timeout_err),
    .done_cnt      (done_cnt)
  );

  // {sample_ready, busy, rst_fsm_ln_ff, begin_fsm_ln, data_valid, timeout_err}
  function automatic logic [5:0] ctrl_now();
    return {sample_ready, busy, rst_fsm_ln_ff, begin_fsm_ln, data_valid, timeout_err};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full request from idle back to idle. d = wait cycle carrying the ack
  // (d >= TO_CYC means no ack at all), r = cycles of DATA_READY low in OUT,
  // stale = ack level already high before and through the clear/start cycles.
  task automatic do_request(input string tag, input logic [31:0] s, input logic [31:0] res,
                            input int d, input int r, input bit stale);
    bit          tmo;
    int          last;
    logic [5:0]  e_ctrl;
    logic [31:0] e_dout;
    tmo  = (d >= int'(TO_CYC));
    last = tmo ? 3 + int'(TO_CYC) : 4 + d + r;

    vectors++;
    if (ctrl_now() !== 6'b100000) begin
      miscompares++;
      $display("FAIL %s accept: ctrl got %b want %b", tag, ctrl_now(), 6'b100000);
    end
    sample_in    = s;
    sample_valid = 1'b1;
    ack_ff       = stale;
    result       = $urandom;
    data_ready   = 1'($urandom);
    tick();

    for (int i = 1; i <= last; i++) begin
      e_ctrl = {1'b0, 1'b1,
                (i == 1) || (tmo && i == last),
                (i == 2),
                !tmo && (i >= 4 + d),
                tmo && (i == last)};
      e_dout = (!tmo && i >= 4 + d) ? res : m_dout;
      vectors++;
      if (ctrl_now() !== e_ctrl) begin
        miscompares++;
        $display("FAIL %s ctrl@%0d: got %b want %b", tag, i, ctrl_now(), e_ctrl);
      end
      vectors++;
      if ({t, data_out, done_cnt} !== {s, e_dout, m_done}) begin
        miscompares++;
        $display("FAIL %s data@%0d: got t=%h dout=%h cnt=%h want t=%h dout=%h cnt=%h",
                 tag, i, t, data_out, done_cnt, s, e_dout, m_done);
      end
      // Inputs for this cycle; anything the sequencer must ignore is randomized.
      sample_valid = 1'($urandom);
      sample_in    = $urandom;
      if (stale && i <= 3)        ack_ff = 1'b1;
      else if (i == 3 + d)        ack_ff = 1'b1;
      else if (i < 3 || i > 3 + d) ack_ff = 1'($urandom);
      else                        ack_ff = 1'b0;
      result = (i == 3 + d) ? res : $urandom;
      if (!tmo && i == last)      data_ready = 1'b1;
      else if (tmo || i < 4 + d)  data_ready = 1'($urandom);
      else                        data_ready = 1'b0;
      tick();
    end

    sample_valid = 1'b0;
    ack_ff       = 1'b0;
    data_ready   = 1'b0;
    m_t = s;
    if (!tmo) begin
      m_dout = res;
      m_done = m_done + 16'd1;
    end
    vectors++;
    if (ctrl_now() !== 6'b100000) begin
      miscompares++;
      $display("FAIL %s idle: ctrl got %b want %b", tag, ctrl_now(), 6'b100000);
    end
    vectors++;
    if ({t, data_out, done_cnt} !== {m_t, m_dout, m_done}) begin
      miscompares++;
      $display("FAIL %s idle data: got t=%h dout=%h cnt=%h want t=%h dout=%h cnt=%h",
               tag, t, data_out, done_cnt, m_t, m_dout, m_done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sample_in = '0; sample_valid = 1'b0; ack_ff = 1'b0;
    result = '0; data_ready = 1'b0;
    m_t = '0; m_dout = '0; m_done = '0;
    repeat (3) tick();
    vectors++;
    if ({ctrl_now(), t, data_out, done_cnt} !== 86'd0) begin
      miscompares++;
      $display("FAIL reset_hold: got ctrl=%b t=%h dout=%h cnt=%h want all 0",
               ctrl_now(), t, data_out, done_cnt);
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (sample_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: sample_ready got %b want 0", sample_ready);
    end
    tick();
    vectors++;
    if (ctrl_now() !== 6'b100000) begin
      miscompares++;
      $display("FAIL reset_first_edge: ctrl got %b want %b", ctrl_now(), 6'b100000);
    end
  endtask

  task automatic test_single_conversion();
    do_request("conv_0p1", 32'h3DCCCCCD, 32'h3F800000, 5, 0, 1'b0);
  endtask

  task automatic test_timeout();
    do_request("timeout", 32'h40490FDB, 32'hDEADBEEF, 1000, 0, 1'b0);
  endtask

  task automatic test_ack_boundary();
    do_request("ack_at_term", 32'h3F000001, 32'h12345678, int'(TO_CYC) - 1, 1, 1'b0);
    do_request("ack_past_term", 32'h3F000002, 32'h87654321, int'(TO_CYC), 1, 1'b0);
  endtask

  task automatic test_backpressure();
    do_request("backpressure", 32'h41200000, 32'h40000000, 2, 20, 1'b0);
  endtask

  task automatic test_stale_ack();
    do_request("pre_stale", 32'h3E800000, 32'h3F400000, 3, 0, 1'b0);
    ack_ff = 1'b1;
    repeat (3) begin
      result = $urandom;
      tick();
      vectors++;
      if ({ctrl_now(), data_out} !== {6'b100000, m_dout}) begin
        miscompares++;
        $display("FAIL stale_idle: got ctrl=%b dout=%h want ctrl=%b dout=%h",
                 ctrl_now(), data_out, 6'b100000, m_dout);
      end
    end
    do_request("stale_ack", 32'h3F000000, 32'h3F3504F3, 0, 2, 1'b1);
  endtask

  task automatic test_random();
    int d;
    int r;
    bit stale;
    for (int n = 0; n < 40; n++) begin
      d     = int'($urandom_range(10, 0));
      r     = int'($urandom_range(4, 0));
      stale = ($urandom_range(7, 0) == 0);
      if (stale) d = 0;
      do_request("random", $urandom, $urandom, d, r, stale);
    end
  endtask

  task automatic test_reset_mid();
    sample_in = 32'h3F800000; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    repeat (4) tick();   // now in the third WAIT_ACK cycle
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({ctrl_now(), t, data_out, done_cnt} !== 86'd0) begin
      miscompares++;
      $display("FAIL reset_mid_async: got ctrl=%b t=%h dout=%h cnt=%h want all 0",
               ctrl_now(), t, data_out, done_cnt);
    end
    m_t = '0; m_dout = '0; m_done = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (sample_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_release: sample_ready got %b want 0", sample_ready);
    end
    tick();
    vectors++;
    if (ctrl_now() !== 6'b100000) begin
      miscompares++;
      $display("FAIL reset_mid_edge: ctrl got %b want %b", ctrl_now(), 6'b100000);
    end
  endtask

  task automatic test_done_wrap();
    do_request("pre_wrap", 32'h3C23D70A, 32'h3F000000, 1, 0, 1'b0);
    // Bring the delivered count to its last value before wrapping.
    force dut.done_cnt = 16'hFFFF;
    #1;
    release dut.done_cnt;
    m_done = 16'hFFFF;
    vectors++;
    if (done_cnt !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL wrap_preload: done_cnt got %h want %h", done_cnt, 16'hFFFF);
    end
    do_request("wrap", 32'h3F19999A, 32'h3F666666, 2, 1, 1'b0);
    vectors++;
    if (done_cnt !== 16'h0000) begin
      miscompares++;
      $display("FAIL wrap_result: done_cnt got %h want %h", done_cnt, 16'h0000);
    end
  endtask

  initial begin
    test_reset();
    test_single_conversion();
    test_timeout();
    test_ack_boundary();
    test_backpressure();
    test_stale_ack();
    test_random();
    test_reset_mid();
    test_single_conversion();
    test_done_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
